// File: rtl/datapath_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared types and constants for the multi-cycle RV32I-subset control
// sequencer: FSM state encoding, instruction class, opcode/funct3 values
// and the ALU operation selector encoding.
// ---------------------------------------------------------------------------
package datapath_ctrl_pkg;

  // State encodings are visible on state_out, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } instr_class_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_opcode_decoder
// Purely combinational classifier for the supported instruction subset.
//   opcode      : instruction[6:0]
//   funct3      : instruction[14:12]
//   instr_class : R / I / LOAD / STORE / BRANCH, or NONE when unsupported
//   illegal     : high when the word is outside the supported subset
// ---------------------------------------------------------------------------
module ctrl_opcode_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_t instr_class,
  output logic         illegal
);

  // Only word-sized loads/stores and beq/bne are implemented; every other
  // funct3 under those opcodes is treated as an unsupported instruction.
  always_comb begin
    instr_class = CLS_NONE;
    case (opcode)
      OPC_RTYPE:  instr_class = CLS_R;
      OPC_ITYPE:  instr_class = CLS_I;
      OPC_LOAD:   if (funct3 == F3_WORD) instr_class = CLS_LOAD;
      OPC_STORE:  if (funct3 == F3_WORD) instr_class = CLS_STORE;
      OPC_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) instr_class = CLS_BRANCH;
      default:    instr_class = CLS_NONE;
    endcase
    illegal = (instr_class == CLS_NONE);
  end

endmodule

// File: rtl/datapath_control_fsm.sv
// ---------------------------------------------------------------------------
// datapath_control_fsm
// Multi-cycle control sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
// [MEM] -> [WRITEBACK], with a memory-wait timeout into a sticky FAULT.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   start          : run enable, only looked at on instruction boundaries
//   instruction    : IR contents (stable from DECODE to end of instruction)
//   zero           : ALU zero flag, used by branches in EXECUTE
//   mem_ready      : memory completes the pending access this cycle
//   ir_write .. alu_op : datapath selectors and memory requests
//   busy, fault, state_out : status and debug
// ---------------------------------------------------------------------------
module datapath_control_fsm
  import datapath_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state_out
);

  state_t             state, state_next;
  instr_class_t       cls_q, dec_class;
  logic               dec_illegal;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout;
  logic               branch_take;
  logic               unused_instr_bits;

  ctrl_opcode_decoder u_decoder (
    .opcode      (instruction[6:0]),
    .funct3      (instruction[14:12]),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  // The counter value reached on the last permitted wait cycle.
  assign timeout = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  // Only beq/bne reach EXECUTE as branches, so funct3 bit 0 alone would do,
  // but the full compare keeps the intent readable.
  assign branch_take = (instruction[14:12] == F3_BEQ) ? zero : !zero;

  assign state_out = state;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Wait counter: restarts on every state change, counts stalled cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (state_next != state)
      wait_cnt <= '0;
    else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Instruction class is captured once in DECODE and steers the rest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                cls_q <= CLS_NONE;
    else if (state == ST_DECODE) cls_q <= dec_class;
  end

  // Next-state and output decode. pc_write/pc_src in EXECUTE follow zero
  // combinationally so a branch resolves in the same cycle.
  always_comb begin
    state_next = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_OP_ADD;
    busy       = 1'b1;
    fault      = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end

      ST_DECODE: begin
        state_next = dec_illegal ? ST_FAULT : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (cls_q)
          CLS_R: begin
            alu_op     = ALU_OP_RFUNCT;
            state_next = ST_WRITEBACK;
          end
          CLS_I: begin
            alu_src    = 1'b1;
            alu_op     = ALU_OP_IFUNCT;
            state_next = ST_WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src    = 1'b1;
            state_next = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op     = ALU_OP_SUB;
            pc_write   = branch_take;
            pc_src     = branch_take;
            state_next = start ? ST_FETCH : ST_IDLE;
          end
          default: state_next = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        iord      = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls_q == CLS_LOAD);
        mem_write = (cls_q == CLS_STORE);
        if (mem_ready)
          state_next = (cls_q == CLS_LOAD) ? ST_WRITEBACK
                     : (start ? ST_FETCH : ST_IDLE);
        else if (timeout)
          state_next = ST_FAULT;
      end

      ST_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LOAD);
        state_next = start ? ST_FETCH : ST_IDLE;
      end

      ST_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end

      default: begin
        busy       = 1'b0;
        state_next = ST_FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_datapath_control_fsm
// Directed bench for the control sequencer. Each instruction is described
// by its wait counts, zero flag and final start value; the bench expands
// that into the expected per-cycle control vector and a checker compares
// the DUT against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_datapath_control_fsm;

  localparam int WAIT_LIMIT = 15;

  typedef struct packed {
    logic [2:0] st;
    logic ir, pw, ps, iord, mr, mw, as, m2r, rw;
    logic [1:0] op;
    logic busy, flt;
  } ctl_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, pc_src, iord, mem_read, mem_write;
  logic        alu_src, mem_to_reg, reg_write, busy, fault;
  logic [1:0]  alu_op;
  logic [2:0]  state_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] curInstr = 32'h0;
  bit          inIdle = 1'b1;
  ctl_t        expQ[$];
  string       tagQ[$];

  datapath_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .instruction (instruction),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_op      (alu_op),
    .busy        (busy),
    .fault       (fault),
    .state_out   (state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected-vector builders, one per phase of an instruction.
  function automatic ctl_t mk(input logic [2:0] st, input logic ir, pw, ps, io,
                              mr, mw, as, m2r, rw, input logic [1:0] op);
    ctl_t e;
    e = '{st: st, ir: ir, pw: pw, ps: ps, iord: io, mr: mr, mw: mw, as: as,
          m2r: m2r, rw: rw, op: op, busy: (st != 3'd0 && st != 3'd7),
          flt: (st == 3'd7)};
    return e;
  endfunction

  function automatic ctl_t expIdle();
    return mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t expFetch(input logic rdy);
    return mk(3'd1, rdy, rdy, 0, 0, 1, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t expDecode();
    return mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t expMem(input logic isLoad);
    return mk(3'd4, 0, 0, 0, 1, isLoad, !isLoad, 1, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t expWb(input logic isLoad);
    return mk(3'd5, 0, 0, 0, 0, 0, 0, 0, isLoad, 1, 2'b00);
  endfunction
  function automatic ctl_t expFault();
    return mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction

  // 0 = unsupported, 1 = R, 2 = I, 3 = LOAD, 4 = STORE, 5 = BRANCH
  function automatic int classOf(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h33:   return 1;
      7'h13:   return 2;
      7'h03:   return (f3 == 3'd2) ? 3 : 0;
      7'h23:   return (f3 == 3'd2) ? 4 : 0;
      7'h63:   return (f3 == 3'd0 || f3 == 3'd1) ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and queues the
  // control vector the DUT must show for that cycle.
  task automatic applyStimulus(input logic st, input logic rdy, input logic z,
                               input ctl_t e, input string tag);
    @(posedge clock);
    #1;
    instruction = curInstr;
    start       = st;
    mem_ready   = rdy;
    zero        = z;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Per-cycle comparison against the queued expectations.
  always @(negedge clock) begin
    ctl_t  act;
    ctl_t  e;
    string tag;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      act = {state_out, ir_write, pc_write, pc_src, iord, mem_read, mem_write,
             alu_src, mem_to_reg, reg_write, alu_op, busy, fault};
      checks++;
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", tag, act, e);
      end
    end
  end

  task automatic doReset(input string tag);
    @(negedge clock);
    #1;
    start     = 1'b0;
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkOutput({tag, " state"}, 32'(state_out), 32'd0);
    checkOutput({tag, " ctl"}, 32'({ir_write, pc_write, pc_src, iord, mem_read,
                mem_write, alu_src, mem_to_reg, reg_write, alu_op, busy, fault}), 32'd0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    inIdle  = 1'b1;
  endtask

  // A FETCH or MEM phase: w stall cycles, then ready; a stall reaching the
  // wait limit ends the phase in a fault instead.
  task automatic waitPhase(input bit isFetch, input int w, input logic isLoad,
                           input logic st, input logic z, input string tag,
                           inout int cycles, output bit faulted);
    logic rdy;
    faulted = 1'b0;
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      rdy = (k == w);
      applyStimulus(st, rdy, z, isFetch ? expFetch(rdy) : expMem(isLoad), tag);
      cycles++;
      if (rdy) return;
    end
    faulted = 1'b1;
  endtask

  task automatic runInstr(input string name, input logic [31:0] instr,
                          input int fw, input int mw, input logic z,
                          input logic stEnd, input int expCycles);
    int   cycles;
    int   cls;
    bit   faulted;
    logic take;
    ctl_t ex;
    cycles   = 0;
    curInstr = instr;
    cls      = classOf(instr);
    take     = (instr[14:12] == 3'd0) ? z : !z;
    if (inIdle) applyStimulus(1'b1, 1'b1, z, expIdle(), {name, "/idle"});
    waitPhase(1'b1, fw, 1'b0, stEnd, z, {name, "/fetch"}, cycles, faulted);
    if (!faulted) begin
      applyStimulus(stEnd, 1'b1, z, expDecode(), {name, "/decode"});
      cycles++;
      if (cls == 0) faulted = 1'b1;
      else begin
        case (cls)
          1:       ex = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
          2:       ex = mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b11);
          5:       ex = mk(3'd3, 0, take, take, 0, 0, 0, 0, 0, 0, 2'b01);
          default: ex = mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
        endcase
        applyStimulus(stEnd, 1'b1, z, ex, {name, "/exec"});
        cycles++;
        if (cls == 3 || cls == 4)
          waitPhase(1'b0, mw, (cls == 3), stEnd, z, {name, "/mem"}, cycles, faulted);
        if (!faulted && cls <= 3) begin
          applyStimulus(stEnd, 1'b1, z, expWb(cls == 3), {name, "/wb"});
          cycles++;
        end
      end
    end
    checkOutput({name, " cycles"}, 32'(cycles), 32'(expCycles));
    if (faulted) begin
      for (int k = 0; k < 3; k++)
        applyStimulus(1'b1, 1'b1, z, expFault(), {name, "/fault"});
      doReset({name, " reset"});
    end else begin
      inIdle = !stEnd;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    instruction = 32'h0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    doReset("power-on");

    runInstr("add",      32'h002081B3, 0,  0,  1'b0, 1'b1, 4);
    runInstr("lw_w3",    32'h0080A283, 0,  3,  1'b0, 1'b1, 8);
    runInstr("sw_w2",    32'h0050A623, 0,  2,  1'b0, 1'b1, 6);
    runInstr("beq_z1",   32'h00208463, 0,  0,  1'b1, 1'b1, 3);
    runInstr("beq_z0",   32'h00208463, 0,  0,  1'b0, 1'b1, 3);
    runInstr("bne_z1",   32'h00209463, 0,  0,  1'b1, 1'b1, 3);
    runInstr("bne_z0",   32'h00209463, 2,  0,  1'b0, 1'b0, 5);
    runInstr("addi",     32'h00108093, 1,  0,  1'b1, 1'b0, 5);
    runInstr("lw_max",   32'h0080A283, 14, 14, 1'b0, 1'b0, 33);
    runInstr("fetch_to", 32'h002081B3, 15, 0,  1'b0, 1'b1, 15);
    runInstr("mem_to",   32'h0080A283, 0,  15, 1'b0, 1'b1, 18);
    runInstr("illegal",  32'hFFFFFFFF, 0,  0,  1'b0, 1'b1, 2);
    runInstr("blt",      32'h0020C463, 0,  0,  1'b1, 1'b1, 2);

    // Reset while a store is stalled in MEM.
    curInstr = 32'h0050A623;
    applyStimulus(1'b1, 1'b1, 1'b0, expIdle(),      "rstmem/idle");
    applyStimulus(1'b1, 1'b1, 1'b0, expFetch(1'b1), "rstmem/fetch");
    applyStimulus(1'b1, 1'b1, 1'b0, expDecode(),    "rstmem/decode");
    applyStimulus(1'b1, 1'b1, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00),
                  "rstmem/exec");
    applyStimulus(1'b1, 1'b0, 1'b0, expMem(1'b0),   "rstmem/mem0");
    applyStimulus(1'b1, 1'b0, 1'b0, expMem(1'b0),   "rstmem/mem1");
    @(negedge clock);
    #1;
    checkOutput("midmem mem_write", 32'(mem_write), 32'd1);
    start   = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("async mem_write", 32'(mem_write), 32'd0);
    checkOutput("async iord",      32'(iord),      32'd0);
    checkOutput("async state",     32'(state_out), 32'd0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    inIdle  = 1'b1;
    runInstr("add_after_rst", 32'h002081B3, 0, 0, 1'b0, 1'b0, 4);

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
